// File: rtl/emergency_preempt.sv
// Emergency-vehicle preemption controller between the phase sequencer and the lamp drivers.
// Build macro EMERGENCY_LATCH_EN makes approach requests sticky until that approach is served.
module emergency_preempt #(
  parameter int NUM_LANES  = 8,
  parameter int TIME_W     = 7,
  parameter int CLEAR_TIME = 3,
  parameter int HOLD_TIME  = 5,
  parameter int MAX_EXT    = 20
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_LANES-1:0]   emergencyLane,
  input  logic [NUM_LANES-1:0]   normalLane,
  output logic [NUM_LANES-1:0]   laneOutput,
  output logic                   loadCommand,
  output logic [TIME_W-1:0]      loadTime,
  output logic                   preemptActive,
  output logic [NUM_LANES/2-1:0] grantAppr
);

  localparam int NUM_APPR = NUM_LANES / 2;
  localparam int PTR_W    = (NUM_APPR > 1) ? $clog2(NUM_APPR) : 1;
  localparam logic [TIME_W-1:0] CLEAR_T = TIME_W'(CLEAR_TIME);
  localparam logic [TIME_W-1:0] HOLD_T  = TIME_W'(HOLD_TIME);
  localparam logic [TIME_W-1:0] MAX_E   = TIME_W'(MAX_EXT);

  if (NUM_LANES < 2 || (NUM_LANES % 2) != 0) begin : g_chk_lanes
    $error("emergency_preempt: NUM_LANES must be even and at least 2");
  end
  if (CLEAR_TIME < 1 || CLEAR_TIME >= (1 << TIME_W)) begin : g_chk_clear
    $error("emergency_preempt: CLEAR_TIME must be >= 1 and fit in TIME_W bits");
  end
  if (HOLD_TIME < 1 || HOLD_TIME >= (1 << TIME_W)) begin : g_chk_hold
    $error("emergency_preempt: HOLD_TIME must be >= 1 and fit in TIME_W bits");
  end
  if (MAX_EXT < 0 || MAX_EXT >= (1 << TIME_W)) begin : g_chk_ext
    $error("emergency_preempt: MAX_EXT must be >= 0 and fit in TIME_W bits");
  end

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_SERVE, S_RECOVER} state_t;

  state_t               state_q, state_d;
  logic [TIME_W-1:0]    count_q, count_d;
  logic [TIME_W-1:0]    ext_q, ext_d;
  logic [PTR_W-1:0]     rr_q, rr_d;
  logic [PTR_W-1:0]     win_q, win_d;
  logic [NUM_APPR-1:0]  live_q, live_d;
  logic                 conflict_q, conflict_d;
  logic                 load_q, load_d;
  logic [TIME_W-1:0]    load_time_q, load_time_d;
  logic [NUM_APPR-1:0]  grant_q, grant_d;
  logic                 active_q, active_d;

  logic [NUM_APPR-1:0]  raw_req;
  logic [NUM_APPR-1:0]  appr_req;
  logic [NUM_APPR-1:0]  clr_mask;
  logic [NUM_APPR-1:0]  win_oh;
  logic                 any_req;
  logic [NUM_LANES-1:0] serve_lanes;
  logic [NUM_LANES-1:0] lane_out;

  function automatic logic [NUM_APPR-1:0] onehot(input logic [PTR_W-1:0] idx);
    logic [NUM_APPR-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NUM_APPR - 1)) ? '0 : p + 1'b1;
  endfunction

  // First requesting approach at or after ptr, wrapping past the last approach.
  function automatic logic [PTR_W-1:0] pick(input logic [NUM_APPR-1:0] req,
                                            input logic [PTR_W-1:0]    ptr);
    logic [PTR_W-1:0] res;
    logic             found;
    int               idx;
    res   = ptr;
    found = 1'b0;
    for (int i = 0; i < NUM_APPR; i++) begin
      idx = (int'(ptr) + i) % NUM_APPR;
      if (!found && req[idx[PTR_W-1:0]]) begin
        res   = idx[PTR_W-1:0];
        found = 1'b1;
      end
    end
    return res;
  endfunction

  for (genvar k = 0; k < NUM_APPR; k++) begin : g_appr
    assign raw_req[k]           = emergencyLane[2*k] | emergencyLane[2*k+1];
    assign serve_lanes[2*k]     = grant_q[k];
    assign serve_lanes[2*k+1]   = grant_q[k];
  end

  always_comb begin
    live_d     = raw_req;
    conflict_d = &emergencyLane;
  end

`ifdef EMERGENCY_LATCH_EN
  logic [NUM_APPR-1:0] sticky_q, sticky_d;

  always_comb begin
    sticky_d = (sticky_q & ~clr_mask) | raw_req;
  end

  always_ff @(posedge clk) begin
    if (reset) sticky_q <= '0;
    else       sticky_q <= sticky_d;
  end

  assign appr_req = sticky_q;
`else
  assign appr_req = live_q;
`endif

  assign any_req = |appr_req;

  // A pulse-emitting transition waits one cycle if the previous cycle already pulsed.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    ext_d       = ext_q;
    rr_d        = rr_q;
    win_d       = win_q;
    load_d      = 1'b0;
    load_time_d = load_time_q;
    clr_mask    = '0;
    win_oh      = onehot(win_q);
    case (state_q)
      S_IDLE: begin
        if (any_req && !load_q) begin
          state_d     = S_CLEAR;
          count_d     = CLEAR_T - 1'b1;
          load_d      = 1'b1;
          load_time_d = CLEAR_T;
        end
      end
      S_CLEAR: begin
        if (count_q != '0) begin
          count_d = count_q - 1'b1;
        end else if (!conflict_q) begin
          if (!any_req) begin
            state_d = S_RECOVER;
            count_d = CLEAR_T - 1'b1;
          end else if (!load_q) begin
            state_d     = S_SERVE;
            win_d       = pick(appr_req, rr_q);
            count_d     = HOLD_T - 1'b1;
            ext_d       = '0;
            load_d      = 1'b1;
            load_time_d = HOLD_T;
          end
        end
      end
      S_SERVE: begin
        if (count_q != '0) begin
          count_d = count_q - 1'b1;
        end else if (|(live_q & win_oh) && (ext_q < MAX_E)) begin
          ext_d = ext_q + 1'b1;
        end else if (!load_q) begin
          rr_d     = next_ptr(win_q);
          clr_mask = win_oh;
          if (|(appr_req & ~win_oh)) begin
            state_d     = S_CLEAR;
            count_d     = CLEAR_T - 1'b1;
            load_d      = 1'b1;
            load_time_d = CLEAR_T;
          end else begin
            state_d = S_RECOVER;
            count_d = CLEAR_T - 1'b1;
          end
        end
      end
      S_RECOVER: begin
        if (any_req) begin
          state_d     = S_CLEAR;
          count_d     = CLEAR_T - 1'b1;
          load_d      = 1'b1;
          load_time_d = CLEAR_T;
        end else if (count_q != '0) begin
          count_d = count_q - 1'b1;
        end else begin
          state_d     = S_IDLE;
          load_d      = 1'b1;
          load_time_d = CLEAR_T;
        end
      end
      default: state_d = S_IDLE;
    endcase
    grant_d  = (state_d == S_SERVE) ? onehot(win_d) : '0;
    active_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      ext_q       <= '0;
      rr_q        <= '0;
      win_q       <= '0;
      live_q      <= '0;
      conflict_q  <= 1'b0;
      load_q      <= 1'b0;
      load_time_q <= '0;
      grant_q     <= '0;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      ext_q       <= ext_d;
      rr_q        <= rr_d;
      win_q       <= win_d;
      live_q      <= live_d;
      conflict_q  <= conflict_d;
      load_q      <= load_d;
      load_time_q <= load_time_d;
      grant_q     <= grant_d;
      active_q    <= active_d;
    end
  end

  // Lamps are dark while reset is held; otherwise IDLE passes the normal sequencer through.
  always_comb begin
    lane_out = '0;
    if (!reset) begin
      case (state_q)
        S_IDLE:  lane_out = normalLane;
        S_SERVE: lane_out = serve_lanes;
        default: lane_out = '0;
      endcase
    end
  end

  assign laneOutput    = lane_out;
  assign loadCommand   = load_q;
  assign loadTime      = load_time_q;
  assign preemptActive = active_q;
  assign grantAppr     = grant_q;

endmodule

// File: tb/tb_emergency_preempt.sv
// Directed bench for emergency_preempt with default parameters; expectations are hand-derived cycle by cycle.
module tb_emergency_preempt;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] emergencyLane;
  logic [7:0] normalLane;
  logic [7:0] laneOutput;
  logic       loadCommand;
  logic [6:0] loadTime;
  logic       preemptActive;
  logic [3:0] grantAppr;

  int checks = 0;
  int errors = 0;

  emergency_preempt dut (
    .clk          (clk),
    .reset        (reset),
    .emergencyLane(emergencyLane),
    .normalLane   (normalLane),
    .laneOutput   (laneOutput),
    .loadCommand  (loadCommand),
    .loadTime     (loadTime),
    .preemptActive(preemptActive),
    .grantAppr    (grantAppr)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    emergencyLane = 8'h00;
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  initial begin
    // Reset state and IDLE pass-through
    reset = 1'b1; emergencyLane = 8'h00; normalLane = 8'hC0;
    step(2);
    chk("rst_lane",   32'(laneOutput),    32'h00);
    chk("rst_load",   32'(loadCommand),   32'h0);
    chk("rst_ltime",  32'(loadTime),      32'h0);
    chk("rst_active", 32'(preemptActive), 32'h0);
    chk("rst_grant",  32'(grantAppr),     32'h0);
    reset = 1'b0;
    step(1);
    chk("idle_lane",   32'(laneOutput),    32'hC0);
    chk("idle_load",   32'(loadCommand),   32'h0);
    chk("idle_active", 32'(preemptActive), 32'h0);

    // Lane 3 held for 10 sampled cycles: approach 1
    emergencyLane = 8'h08;
    step(1);
    chk("t2_latency_lane", 32'(laneOutput), 32'hC0);
    step(1);
    chk("t2_clr_lane",   32'(laneOutput),    32'h00);
    chk("t2_clr_load",   32'(loadCommand),   32'h1);
    chk("t2_clr_time",   32'(loadTime),      32'h3);
    chk("t2_clr_active", 32'(preemptActive), 32'h1);
    step(1);
    chk("t2_no_back2back", 32'(loadCommand), 32'h0);
    step(2);
    chk("t2_srv_lane",  32'(laneOutput),  32'h0C);
    chk("t2_srv_grant", 32'(grantAppr),   32'h2);
    chk("t2_srv_load",  32'(loadCommand), 32'h1);
    chk("t2_srv_time",  32'(loadTime),    32'h5);
    step(5);
    chk("t2_ext1_grant", 32'(grantAppr), 32'h2);
    emergencyLane = 8'h00;
    step(1);
    chk("t2_ext2_grant", 32'(grantAppr), 32'h2);
    step(1);
    chk("t2_rec_grant",  32'(grantAppr),     32'h0);
    chk("t2_rec_lane",   32'(laneOutput),    32'h00);
    chk("t2_rec_active", 32'(preemptActive), 32'h1);
    chk("t2_rec_load",   32'(loadCommand),   32'h0);
    step(2);
    chk("t2_rec_hold", 32'(preemptActive), 32'h1);
    step(1);
    chk("t2_exit_load",   32'(loadCommand),   32'h1);
    chk("t2_exit_time",   32'(loadTime),      32'h3);
    chk("t2_exit_active", 32'(preemptActive), 32'h0);
    chk("t2_exit_lane",   32'(laneOutput),    32'hC0);
    step(1);
    chk("t2_ltime_hold", 32'(loadTime),    32'h3);
    chk("t2_load_low",   32'(loadCommand), 32'h0);

    // Lanes 0 and 6 held: approach 0 first, then approach 3
    do_reset();
    emergencyLane = 8'h41;
    step(5);
    chk("t3_first_grant", 32'(grantAppr),  32'h1);
    chk("t3_first_lane",  32'(laneOutput), 32'h03);
    step(24);
    chk("t3_hold25_grant", 32'(grantAppr), 32'h1);
    step(1);
    chk("t3_clr_grant", 32'(grantAppr),   32'h0);
    chk("t3_clr_load",  32'(loadCommand), 32'h1);
    chk("t3_clr_lane",  32'(laneOutput),  32'h00);
    step(3);
    chk("t3_second_grant", 32'(grantAppr),  32'h8);
    chk("t3_second_lane",  32'(laneOutput), 32'hC0);
    emergencyLane = 8'h00;

    // Request held forever: 25 serve cycles, RECOVER, CLEAR, re-serve
    do_reset();
    emergencyLane = 8'h04;
    step(5);
    chk("t4_grant", 32'(grantAppr), 32'h2);
    step(24);
    chk("t4_last_grant", 32'(grantAppr), 32'h2);
    step(1);
    chk("t4_rec_grant",  32'(grantAppr),     32'h0);
    chk("t4_rec_active", 32'(preemptActive), 32'h1);
    chk("t4_rec_load",   32'(loadCommand),   32'h0);
    step(1);
    chk("t4_clr_load", 32'(loadCommand), 32'h1);
    chk("t4_clr_time", 32'(loadTime),    32'h3);
    step(3);
    chk("t4_reserve_grant", 32'(grantAppr), 32'h2);
    chk("t4_reserve_time",  32'(loadTime),  32'h5);
    emergencyLane = 8'h00;

    // All lanes high is a sensor fault: held all-red with no grant
    do_reset();
    emergencyLane = 8'hFF;
    step(4);
    for (int c = 0; c < 4; c++) begin
      step(1);
      chk("t5_hold_load",  32'(loadCommand),   32'h0);
      chk("t5_hold_grant", 32'(grantAppr),     32'h0);
      chk("t5_hold_lane",  32'(laneOutput),    32'h00);
      chk("t5_hold_active", 32'(preemptActive), 32'h1);
    end
    emergencyLane = 8'h7F;
    step(1);
    chk("t5_still_held", 32'(grantAppr), 32'h0);
    step(1);
    chk("t5_grant", 32'(grantAppr),   32'h1);
    chk("t5_lane",  32'(laneOutput),  32'h03);
    chk("t5_load",  32'(loadCommand), 32'h1);
    emergencyLane = 8'h00;

    // Single-cycle pulse on lane 5
    do_reset();
    emergencyLane = 8'h20;
    step(1);
    emergencyLane = 8'h00;
    step(1);
    chk("t6_clr_active", 32'(preemptActive), 32'h1);
    chk("t6_clr_load",   32'(loadCommand),   32'h1);
    step(3);
`ifdef EMERGENCY_LATCH_EN
    chk("t6_latch_grant", 32'(grantAppr),  32'h4);
    chk("t6_latch_lane",  32'(laneOutput), 32'h30);
`else
    chk("t6_rec_grant",  32'(grantAppr),     32'h0);
    chk("t6_rec_lane",   32'(laneOutput),    32'h00);
    chk("t6_rec_active", 32'(preemptActive), 32'h1);
    chk("t6_rec_load",   32'(loadCommand),   32'h0);
    step(3);
    chk("t6_idle_active", 32'(preemptActive), 32'h0);
    chk("t6_idle_load",   32'(loadCommand),   32'h1);
    chk("t6_idle_lane",   32'(laneOutput),    32'hC0);
`endif

    // Reset asserted mid-SERVE
    do_reset();
    emergencyLane = 8'h20;
    step(5);
    chk("t7_pre_grant", 32'(grantAppr),  32'h4);
    chk("t7_pre_lane",  32'(laneOutput), 32'h30);
    step(2);
    reset = 1'b1;
    step(1);
    chk("t7_rst_lane",   32'(laneOutput),    32'h00);
    chk("t7_rst_load",   32'(loadCommand),   32'h0);
    chk("t7_rst_ltime",  32'(loadTime),      32'h0);
    chk("t7_rst_active", 32'(preemptActive), 32'h0);
    chk("t7_rst_grant",  32'(grantAppr),     32'h0);
    reset = 1'b0;
    emergencyLane = 8'h00;
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
